// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flag stage behind the 16-bit ALU.
// Captures each accepted ALU result, derives {C,Z,N,EQ}, buffers it in a
// DEPTH-entry FIFO toward writeback and feeds the last carry back to the ALU.
// The head is held in output registers, so out_* never depend combinationally
// on the inputs and keep the last popped values while the FIFO is empty.
// Optional build macro: ALU_RESULT_PARITY_EN adds out_parity (even parity of
// the stored data word, carried per entry).
module alu_result_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_carry,
    input  logic             in_compare,
    input  logic             in_chain,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
`ifdef ALU_RESULT_PARITY_EN
    output logic             out_parity,
`endif
    output logic             carry_fb,
    output logic [15:0]      op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [15:0]      mem_data  [DEPTH];
    logic [3:0]       mem_flags [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
    logic             mem_par   [DEPTH];
    logic             new_par;
`endif

    logic [PW:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic        full, empty, push, pop, next_empty, head_bypass;
    logic        zsticky, new_z;
    logic [3:0]  new_flags;

    // Full/empty decode: same index, wrap bit tells the two apart.
    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        in_ready    = !full;
        out_valid   = !empty;
        push        = in_valid && !full;
        pop         = !empty && out_ready;
        wr_next     = push ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_next     = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
        next_empty  = (wr_next == rd_next);
        // The word being written becomes the new head when it lands on the slot
        // that rd_ptr will point to; memory does not hold it yet, so take it directly.
        head_bypass = push && (wr_ptr[PW-1:0] == rd_next[PW-1:0]);
    end

    // Flag derivation; zero accumulates across chained words.
    always_comb begin
        new_z     = (in_data == 16'h0000) && (in_chain ? zsticky : 1'b1);
        new_flags = {in_carry, new_z, in_data[15], in_compare};
`ifdef ALU_RESULT_PARITY_EN
        new_par   = ^in_data;
`endif
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[PW-1:0]]  <= in_data;
            mem_flags[wr_ptr[PW-1:0]] <= new_flags;
            mem_tag[wr_ptr[PW-1:0]]   <= in_tag;
`ifdef ALU_RESULT_PARITY_EN
            mem_par[wr_ptr[PW-1:0]]   <= new_par;
`endif
        end
    end

    // Pointers, accept-side state and the registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            zsticky   <= 1'b1;
            carry_fb  <= 1'b0;
            op_count  <= 16'h0000;
            out_data  <= 16'h0000;
            out_flags <= 4'h0;
            out_tag   <= '0;
`ifdef ALU_RESULT_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (push) begin
                zsticky  <= new_z;
                carry_fb <= in_carry;
                op_count <= op_count + 16'h0001;
            end
            if (!next_empty) begin
                if (head_bypass) begin
                    out_data  <= in_data;
                    out_flags <= new_flags;
                    out_tag   <= in_tag;
`ifdef ALU_RESULT_PARITY_EN
                    out_parity <= new_par;
`endif
                end else begin
                    out_data  <= mem_data[rd_next[PW-1:0]];
                    out_flags <= mem_flags[rd_next[PW-1:0]];
                    out_tag   <= mem_tag[rd_next[PW-1:0]];
`ifdef ALU_RESULT_PARITY_EN
                    out_parity <= mem_par[rd_next[PW-1:0]];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_stage;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_carry = 1'b0, in_compare = 1'b0, in_chain = 1'b0;
    logic [15:0]      in_data = 16'h0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, carry_fb;
    logic [15:0]      out_data, op_count;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_parity;
`endif

    alu_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_carry(in_carry), .in_compare(in_compare), .in_chain(in_chain),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_tag(out_tag),
`ifdef ALU_RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .carry_fb(carry_fb), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [15:0]      d;
        logic [3:0]       f;
        logic [TAG_W-1:0] t;
        logic             p;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    int unsigned m_opc;
    logic        m_cfb, m_zs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of result records.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last  = '{d: 16'h0, f: 4'h0, t: '0, p: 1'b0};
            m_opc = 0;
            m_cfb = 1'b0;
            m_zs  = 1'b1;
        end else begin
            bit   do_pop, do_push;
            ent_t e;
            do_pop  = (q.size() > 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) last = q.pop_front();
            if (do_push) begin
                e.d = in_data;
                e.f[3] = in_carry;
                e.f[2] = (in_data == 16'h0) && (!in_chain || m_zs);
                e.f[1] = in_data[15];
                e.f[0] = in_compare;
                e.t = in_tag;
                e.p = ^in_data;
                q.push_back(e);
                m_zs  = e.f[2];
                m_cfb = in_carry;
                m_opc = (m_opc + 1) % 65536;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : last;
            check("out_valid", out_valid, q.size() > 0);
            check("in_ready", in_ready, q.size() < DEPTH);
            check("out_data", out_data, h.d);
            check("out_flags", out_flags, h.f);
            check("out_tag", out_tag, h.t);
            check("carry_fb", carry_fb, m_cfb);
            check("op_count", op_count, m_opc);
`ifdef ALU_RESULT_PARITY_EN
            check("out_parity", out_parity, h.p);
`endif
        end
    end

    task automatic cyc(input bit v, input logic [15:0] d, input bit c, input bit cmp,
                       input bit ch, input int t, input bit ordy);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        in_carry   = c;
        in_compare = cmp;
        in_chain   = ch;
        in_tag     = TAG_W'(t);
        out_ready  = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset then idle
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_carry_fb", carry_fb, 0);
        check("reset_op_count", op_count, 0);
        check("reset_flags", out_flags, 4'b0000);

        // Single accept of 0x8000 with carry
        cyc(1, 16'h8000, 1, 0, 0, 5, 1);
        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 16'h8000);
        check("first_flags", out_flags, 4'b1010);
        check("first_carry_fb", carry_fb, 1);
        check("first_op_count", op_count, 1);

        // Chain zero accumulation, one word per cycle with writeback draining
        cyc(1, 16'h0000, 0, 0, 0, 1, 1);
        cyc(1, 16'h0000, 0, 0, 1, 2, 1);
        check("chain_w1_flags", out_flags, 4'b0100);
        cyc(1, 16'h0001, 0, 0, 1, 3, 1);
        check("chain_w2_flags", out_flags, 4'b0100);
        cyc(1, 16'h0000, 0, 0, 1, 4, 1);
        check("chain_w3_flags", out_flags, 4'b0000);
        check("chain_w3_data", out_data, 16'h0001);
        cyc(0, 16'h0, 0, 0, 0, 0, 1);
        check("chain_w4_flags", out_flags, 4'b0000);

        // Fill with writeback stalled
        do_reset();
        check("fill_rst_op_count", op_count, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'h0100 + 16'(i), 0, 0, 0, i, 0);
        cyc(1, 16'h0ABC, 0, 0, 0, 4, 0);
        check("full_in_ready", in_ready, 0);
        check("full_op_count", op_count, 4);
        cyc(0, 16'h0, 0, 0, 0, 0, 1);
        check("fifth_ignored_op_count", op_count, 4);
        check("full_pop_in_ready", in_ready, 0);
        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        check("after_pop_in_ready", in_ready, 1);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 16'h0, 0, 0, 0, 0, 1);
            check("drain_tag", out_tag, i);
        end
        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        check("drained_valid", out_valid, 0);
        check("drained_hold_tag", out_tag, 3);

        // Continuous push/pop at occupancy 1, crossing the pointer wrap
        do_reset();
        cyc(1, 16'h1000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 16'h1000 + 16'(i), 0, 0, 0, i, 1);
            check("stream_tag", out_tag, (i - 1) % 8);
            check("stream_count1_valid", out_valid, 1);
        end
        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        check("stream_op_count", op_count, 11);
        check("stream_last_tag", out_tag, 2);

        // Reset with three entries buffered
        cyc(1, 16'h2222, 0, 0, 0, 6, 0);
        cyc(1, 16'h3333, 0, 0, 0, 7, 0);
        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_op_count", op_count, 0);
        check("post_rst_out_data", out_data, 0);

        cyc(1, 16'h0007, 0, 1, 0, 1, 0);
        cyc(0, 16'h0, 0, 0, 0, 0, 1);
        check("par_word_data", out_data, 16'h0007);
        check("par_word_flags", out_flags, 4'b0001);
`ifdef ALU_RESULT_PARITY_EN
        check("par_word_parity", out_parity, 1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 7)), $urandom_range(0, 9) < 6);
            end
        end

        cyc(0, 16'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
